// File: rtl/clk_rst_pkg.sv
// Shared types and defaults for the clock-enable / reset controller.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } ch_state_e;

  localparam int unsigned NUM_CH_DEF  = 2;
  localparam int unsigned DIV_W_DEF   = 8;
  localparam int unsigned HOLD_W_DEF  = 8;
  localparam int unsigned DIV_DEF_C   = 1;
  localparam int unsigned HOLD_DEF_C  = 4;
  localparam int unsigned SYNC_STAGES = 2;

  // Channel-index width, never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_rst_chan.sv
// One channel: IDLE/HOLD/RUN/PAUSE sequencer with hold counter, tick divider
// and div/hold shadow registers.
module clk_rst_chan
  import clk_rst_pkg::*;
#(
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned HOLD_W   = HOLD_W_DEF,
  parameter int unsigned DIV_DEF  = DIV_DEF_C,
  parameter int unsigned HOLD_DEF = HOLD_DEF_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              soft_rst,
  input  logic              cfg_wr,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic              tick,
  output logic              rst_out_n,
  output logic              busy,
  output logic              cfg_ok
);

  ch_state_e         state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [HOLD_W-1:0] hold_sh_q, hold_sh_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]  div_run_q, div_run_d;
  logic [DIV_W-1:0]  div_sh_q, div_sh_d;
  logic              div_hit;

  always_comb begin
    // A write in the same cycle as a start is visible to that start.
    div_sh_d   = cfg_wr ? cfg_div : div_sh_q;
    hold_sh_d  = cfg_wr ? cfg_hold : hold_sh_q;
    div_hit    = (div_cnt_q == div_run_q);
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    div_cnt_d  = div_cnt_q;
    div_run_d  = div_run_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HOLD;
          hold_cnt_d = hold_sh_d;
        end
      end
      HOLD: begin
        if (soft_rst) begin
          hold_cnt_d = hold_sh_d;
        end else if (hold_cnt_q == '0) begin
          state_d   = RUN;
          div_cnt_d = '0;
          div_run_d = div_sh_d;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      RUN: begin
        if (soft_rst) begin
          state_d    = HOLD;
          hold_cnt_d = hold_sh_d;
        end else if (stop) begin
          state_d = PAUSE;
        end else begin
          div_cnt_d = div_hit ? '0 : div_cnt_q + DIV_W'(1);
        end
      end
      PAUSE: begin
        if (soft_rst) begin
          state_d    = HOLD;
          hold_cnt_d = hold_sh_d;
        end else if (start) begin
          state_d   = RUN;
          div_cnt_d = '0;
          div_run_d = div_sh_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick      = (state_q == RUN) && div_hit;
    rst_out_n = (state_q == RUN) || (state_q == PAUSE);
    busy      = (state_q == HOLD) || (state_q == RUN);
    cfg_ok    = (state_q == IDLE) || (state_q == PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      div_cnt_q  <= '0;
      div_run_q  <= '0;
      div_sh_q   <= DIV_W'(DIV_DEF);
      hold_sh_q  <= HOLD_W'(HOLD_DEF);
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      div_cnt_q  <= div_cnt_d;
      div_run_q  <= div_run_d;
      div_sh_q   <= div_sh_d;
      hold_sh_q  <= hold_sh_d;
    end
  end

endmodule

// File: rtl/clk_rst_ctrl.sv
// Multi-channel clock-enable / reset controller: reset synchronizer, config
// decode and NUM_CH channel instances.
module clk_rst_ctrl
  import clk_rst_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned HOLD_W   = HOLD_W_DEF,
  parameter int unsigned DIV_DEF  = DIV_DEF_C,
  parameter int unsigned HOLD_DEF = HOLD_DEF_C
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [HOLD_W-1:0]             cfg_hold,
  input  logic [NUM_CH-1:0]             start,
  input  logic [NUM_CH-1:0]             stop,
  input  logic [NUM_CH-1:0]             soft_rst,
  output logic [NUM_CH-1:0]             ch_tick,
  output logic [NUM_CH-1:0]             ch_rst_n,
  output logic [NUM_CH-1:0]             ch_busy
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rst_sync_n;
  logic [NUM_CH-1:0]      ch_cfg_ok;
  logic [NUM_CH-1:0]      cfg_wr;

  // Asserts with arst_n, releases after SYNC_STAGES clock edges; channels are
  // held in reset (and so ignore commands) until then.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1};
    rst_sync_n = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Out-of-range cfg_ch matches no channel, leaving cfg_ready low.
  always_comb begin
    cfg_ready = 1'b0;
    cfg_wr    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(cfg_ch) == i) begin
        cfg_ready = rst_sync_n & ch_cfg_ok[i];
        cfg_wr[i] = cfg_valid & rst_sync_n & ch_cfg_ok[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_rst_chan #(
      .DIV_W    (DIV_W),
      .HOLD_W   (HOLD_W),
      .DIV_DEF  (DIV_DEF),
      .HOLD_DEF (HOLD_DEF)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_sync_n),
      .start     (start[g]),
      .stop      (stop[g]),
      .soft_rst  (soft_rst[g]),
      .cfg_wr    (cfg_wr[g]),
      .cfg_div   (cfg_div),
      .cfg_hold  (cfg_hold),
      .tick      (ch_tick[g]),
      .rst_out_n (ch_rst_n[g]),
      .busy      (ch_busy[g]),
      .cfg_ok    (ch_cfg_ok[g])
    );
  end

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Directed plus random-command bench for clk_rst_ctrl; a cycle model pushes the
// expected outputs to a scoreboard that is popped at each mid-cycle sample.
module tb_clk_rst_ctrl;
  import clk_rst_pkg::*;

  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned HW  = 8;
  localparam int unsigned CW  = ch_idx_w(NCH);
  localparam int M_IDLE = 0, M_HOLD = 1, M_RUN = 2, M_PAUSE = 3;

  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] rstn;
    logic [NCH-1:0] busy;
    logic           rdy;
  } exp_t;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic [HW-1:0]  cfg_hold = '0;
  logic [NCH-1:0] start = '0, stop = '0, soft_rst = '0;
  logic [NCH-1:0] ch_tick, ch_rst_n, ch_busy;

  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   spec_chk = 1'b0;
  exp_t sb[$];

  int m_mode[NCH], m_hold_left[NCH], m_age[NCH];
  int m_div_run[NCH], m_div_sh[NCH], m_hold_sh[NCH];
  int m_sync;

  always #5 clk = ~clk;

  clk_rst_ctrl #(
    .NUM_CH   (NCH),
    .DIV_W    (DW),
    .HOLD_W   (HW),
    .DIV_DEF  (1),
    .HOLD_DEF (4)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_hold  (cfg_hold),
    .start     (start),
    .stop      (stop),
    .soft_rst  (soft_rst),
    .ch_tick   (ch_tick),
    .ch_rst_n  (ch_rst_n),
    .ch_busy   (ch_busy)
  );

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = M_IDLE; m_hold_left[c] = 0; m_age[c] = 0;
      m_div_run[c] = 0; m_div_sh[c] = 1; m_hold_sh[c] = 4;
    end
    m_sync = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (arst_n && m_sync == 2) begin
      for (int c = 0; c < NCH; c++) begin
        e.rstn[c] = (m_mode[c] == M_RUN) || (m_mode[c] == M_PAUSE);
        e.busy[c] = (m_mode[c] == M_HOLD) || (m_mode[c] == M_RUN);
        e.tick[c] = (m_mode[c] == M_RUN) &&
                    ((m_age[c] % (m_div_run[c] + 1)) == m_div_run[c]);
      end
      if (int'(cfg_ch) < NCH)
        e.rdy = (m_mode[cfg_ch] == M_IDLE) || (m_mode[cfg_ch] == M_PAUSE);
    end
    return e;
  endfunction

  function automatic void model_edge(input logic rdy);
    bit wr;
    int nd, nh;
    if (!arst_n) begin
      model_reset();
      return;
    end
    if (m_sync < 2) begin
      m_sync++;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      wr = cfg_valid && rdy && (int'(cfg_ch) == c);
      nd = wr ? int'(cfg_div) : m_div_sh[c];
      nh = wr ? int'(cfg_hold) : m_hold_sh[c];
      case (m_mode[c])
        M_IDLE:
          if (start[c]) begin m_mode[c] = M_HOLD; m_hold_left[c] = nh + 1; end
        M_HOLD:
          if (soft_rst[c]) m_hold_left[c] = nh + 1;
          else begin
            m_hold_left[c]--;
            if (m_hold_left[c] == 0) begin
              m_mode[c] = M_RUN; m_age[c] = 0; m_div_run[c] = nd;
            end
          end
        M_RUN:
          if (soft_rst[c]) begin m_mode[c] = M_HOLD; m_hold_left[c] = nh + 1; end
          else if (stop[c]) m_mode[c] = M_PAUSE;
          else m_age[c]++;
        default:
          if (soft_rst[c]) begin m_mode[c] = M_HOLD; m_hold_left[c] = nh + 1; end
          else if (start[c]) begin
            m_mode[c] = M_RUN; m_age[c] = 0; m_div_run[c] = nd;
          end
      endcase
      m_div_sh[c]  = nd;
      m_hold_sh[c] = nh;
    end
  endfunction

  // Channel 0 timeline written out from cycle numbers: reset released in
  // cycle 0, start in cycle 10, hold 4, div 1.
  task automatic spec_check();
    logic er, et;
    er = (cyc >= 16);
    et = (cyc >= 17) && (((cyc - 17) % 2) == 0);
    vectors++;
    assert (ch_rst_n[0] === er) else begin
      errors++;
      $error("FAIL timeline_rst_n cycle%0d observed=%b required=%b", cyc, ch_rst_n[0], er);
    end
    vectors++;
    assert (ch_tick[0] === et) else begin
      errors++;
      $error("FAIL timeline_tick cycle%0d observed=%b required=%b", cyc, ch_tick[0], et);
    end
  endtask

  task automatic step();
    exp_t e, got;
    e = model_out();
    sb.push_back(e);
    @(negedge clk);
    got = {ch_tick, ch_rst_n, ch_busy, cfg_ready};
    e = sb.pop_front();
    vectors++;
    assert (got === e) else begin
      errors++;
      $error("FAIL outputs cycle%0d observed=%b required=%b (tick,rst_n,busy,rdy)",
             cyc, got, e);
    end
    if (spec_chk) spec_check();
    @(posedge clk);
    model_edge(e.rdy);
    cyc++;
    #1;
    cfg_valid = 1'b0;
    start = '0; stop = '0; soft_rst = '0;
  endtask

  task automatic write_cfg(input int ch, input int d, input int h);
    cfg_valid = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_div   = DW'(d);
    cfg_hold  = HW'(h);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    repeat (3) step();

    // Release reset, start ch0 in cycle 10 with default hold/div.
    arst_n = 1'b1;
    cyc = 0;
    repeat (5) step();
    soft_rst[1] = 1'b1;
    step();
    repeat (4) step();
    start[0] = 1'b1;
    spec_chk = 1'b1;
    repeat (13) step();
    spec_chk = 1'b0;

    // ch1: div=0, hold=0 -> single HOLD cycle then tick every cycle.
    write_cfg(1, 0, 0); step();
    start[1] = 1'b1; step();
    repeat (5) step();

    // Write to a running channel is refused; write in PAUSE applies on resume.
    write_cfg(0, 7, 7); step();
    stop[0] = 1'b1; step();
    write_cfg(0, 3, 2); step();
    repeat (2) step();
    start[0] = 1'b1; step();
    repeat (9) step();

    // Stop, resume five cycles later.
    stop[0] = 1'b1; step();
    repeat (4) step();
    start[0] = 1'b1; step();
    repeat (8) step();

    // soft_rst wins over stop and start; soft_rst inside HOLD reloads.
    soft_rst[0] = 1'b1; stop[0] = 1'b1; start[0] = 1'b1; step();
    repeat (6) step();
    soft_rst[0] = 1'b1; step();
    soft_rst[0] = 1'b1; step();
    repeat (5) step();

    // soft_rst from PAUSE; write and start together from PAUSE.
    stop[1] = 1'b1; step();
    soft_rst[1] = 1'b1; step();
    repeat (3) step();
    stop[1] = 1'b1; step();
    write_cfg(1, 2, 1); start[1] = 1'b1; step();
    repeat (6) step();

    // Asynchronous reset mid-RUN: outputs fall with no clock edge.
    arst_n = 1'b0;
    #1;
    vectors++;
    assert ({ch_tick, ch_rst_n, ch_busy} === '0) else begin
      errors++;
      $error("FAIL async_reset observed=%b required=0", {ch_tick, ch_rst_n, ch_busy});
    end
    repeat (3) step();
    arst_n = 1'b1;
    start = '1; step();
    start = '1; write_cfg(0, 5, 5); step();
    write_cfg(0, 0, 1); start[0] = 1'b1; step();
    start[1] = 1'b1; step();
    repeat (10) step();

    // Random command mix.
    for (int n = 0; n < 80; n++) begin
      for (int c = 0; c < NCH; c++) begin
        start[c]    = ($urandom_range(0, 3) == 0);
        stop[c]     = ($urandom_range(0, 5) == 0);
        soft_rst[c] = ($urandom_range(0, 11) == 0);
      end
      if ($urandom_range(0, 2) == 0)
        write_cfg(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
